dose_sequencer: RTL and testbench
=================================

# dose_sequencer

Downstream stage of the dispense-time / circuit-control logic: consumes one-cycle morning, afternoon, evening and manual dose requests and drives the carousel stepper one slot per dose. After each advance it waits for the pill-drop sensor, nudges and retries on a miss, and raises a latched alarm for a caregiver when retries run out or the cartridge is empty. Requests that arrive while a dose is in flight are queued, one per dose type.

## Interface
- STEP_DIV, 50000: CLOCK_50 cycles per stepper step (1 kHz).
- STEPS_PER_SLOT, 200: steps per full slot advance.
- NUDGE_STEPS, 8: steps per retry nudge.
- DROP_TIMEOUT, 25000000: cycles to wait in WAIT_DROP (0.5 s).
- MAX_RETRY, 2: nudges allowed before alarm.
- NUM_SLOTS, 21: cartridge slots (7 days x 3).
- CLOCK_50  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-low; clears all state and outputs.
- morningReq, afternoonReq, eveningReq, manualReq  in  1 each  one-cycle request pulses.
- pillSensor  in  1  drop sensor (GPIO), asynchronous, active-high.
- ack  in  1  one-cycle caregiver acknowledge / refill pulse.
- stepPulse  out  1  one-cycle step strobe. Reset 0.
- motorEnable  out  1  high in ARM, STEP, NUDGE and WAIT_DROP. Reset 0.
- slotIndex  out  5  next slot to dispense. Reset 0.
- doseType  out  2  dose in flight: 00 manual, 01 morning, 10 afternoon, 11 evening. Reset 00.
- busy  out  1  state is not IDLE. Reset 0.
- doneP  out  1  one-cycle pulse on a confirmed drop. Reset 0.
- alarm  out  1  high in ALARM and EMPTY. Reset 0.
- empty  out  1  high in EMPTY. Reset 0.
- missedCount  out  4  failed or dropped doses, saturates at 15. Reset 0.

## Operation
- **Pending flags:** one per dose type. A request pulse sets its flag in any state. A repeat request on an already-set flag is absorbed with no count.
- **Priority in IDLE:** morning > afternoon > evening > manual. The selected flag clears on the edge that enters ARM, and doseType is loaded on the same edge.
- **ARM:** lasts one cycle and loads the step counter with STEPS_PER_SLOT. Next state is STEP.
- **STEP / NUDGE:**
  - The divider counts 0..STEP_DIV-1. stepPulse is high on the cycle the divider equals STEP_DIV-1, and the step counter decrements on that cycle.
  - When the counter reaches 0, the divider and retry timer clear and the state moves to WAIT_DROP.
- **WAIT_DROP:** the timeout counter runs.
  - A synchronised rising edge of pillSensor gives doneP and the DONE path.
  - On timeout with retry < MAX_RETRY: retry++, load NUDGE_STEPS, go to NUDGE.
  - On timeout otherwise: missedCount++ and go to ALARM.
  - Sensor edges outside WAIT_DROP are ignored.
- **DONE path** (also applies on the ack that leaves ALARM): the retry count clears.
  - slotIndex==NUM_SLOTS-1 → EMPTY.
  - Otherwise slotIndex++ and return to IDLE.
- **ALARM:** held until ack, then DONE path. The slot is consumed even though the dose failed.
- **EMPTY:**
  - Any request received (or flag still pending on entry) is discarded and adds 1 to missedCount, saturating.
  - ack sets slotIndex to 0, clears all flags and goes to IDLE.
- **Edge cases:**
  - A request and ack in the same cycle in ALARM: the request flag is set before the return to IDLE.
  - Simultaneous requests of several types: all flags set and are served in priority order, back-to-back.
- **Reset mid-rotation:** motorEnable and stepPulse drop asynchronously and slotIndex returns to 0. The carousel must be re-homed by the operator.

## Timing
- Request high at edge t → ARM after t; busy and motorEnable high from t+1.
- STEP is entered at edge t+1. The first stepPulse is high in cycle t+1+STEP_DIV.
- A full slot advance takes STEPS_PER_SLOT*STEP_DIV cycles from STEP entry to WAIT_DROP entry.
- pillSensor passes through a 2-flop synchroniser plus an edge register. doneP is high 3 cycles after the sensor rise, provided the state is WAIT_DROP.
- Timeout fires on the DROP_TIMEOUT-th cycle in WAIT_DROP.
- The next queued dose enters ARM 2 cycles after doneP (DONE path edge, then IDLE).

## Structure
- **Shared package dispenser_pkg:**
  - State enum: IDLE, ARM, STEP, NUDGE, WAIT_DROP, ALARM, EMPTY.
  - doseType codes.
  - Default parameter constants.
- **Sub-module step_gen:** divider plus down-counter.
  - Inputs: load, count, enable.
  - Outputs: stepPulse, finished.
  - Reused by STEP and NUDGE.
- The synchroniser and sequencer FSM stay in the top module.

## Test plan
All scenarios use STEP_DIV=4, STEPS_PER_SLOT=5, NUDGE_STEPS=2, DROP_TIMEOUT=20, MAX_RETRY=2, NUM_SLOTS=3.
1. **Single dose:** morningReq at cycle 10, pillSensor rise during WAIT_DROP → 5 stepPulses (first at cycle 15), doseType=01, doneP 3 cycles after the rise, slotIndex 0→1, busy low 1 cycle later.
2. **Simultaneous requests:** eveningReq and afternoonReq in the same cycle, each confirmed → afternoon (10) served then evening (11), back-to-back; slotIndex ends at 2.
3. **Retry then alarm:** no sensor → 2 nudges of 2 stepPulses each, then alarm=1 and missedCount=1. ack → alarm 0, slotIndex advances.
4. **Empty cartridge:** three confirmed doses → empty=1 and alarm=1. manualReq while EMPTY → missedCount+1. ack → slotIndex=0, IDLE.
5. **Reset mid-STEP:** reset low after 2 stepPulses → motorEnable=0 in the same cycle, all outputs at reset values, pending flags cleared.
6. **Sensor glitch outside WAIT_DROP:** pillSensor pulse during STEP → no doneP. A sensor rise during WAIT_DROP then produces the only doneP.

Source files
------------

// File: rtl/dispenser_pkg.sv
// Shared types and default constants for the pill-dispenser sequencer.
// Dose codes double as indices into the pending-request vector.
package dispenser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STEP,
    S_NUDGE,
    S_WAIT_DROP,
    S_ALARM,
    S_EMPTY
  } state_e;

  typedef enum logic [1:0] {
    DOSE_MANUAL    = 2'b00,
    DOSE_MORNING   = 2'b01,
    DOSE_AFTERNOON = 2'b10,
    DOSE_EVENING   = 2'b11
  } dose_e;

  localparam int STEP_DIV_DEF       = 50000;
  localparam int STEPS_PER_SLOT_DEF = 200;
  localparam int NUDGE_STEPS_DEF    = 8;
  localparam int DROP_TIMEOUT_DEF   = 25000000;
  localparam int MAX_RETRY_DEF      = 2;
  localparam int NUM_SLOTS_DEF      = 21;
  localparam int CNT_W              = 16;

  function automatic logic [3:0] sat_add(
    input logic [3:0] a,
    input logic [2:0] n
  );
    logic [4:0] s;
    s = {1'b0, a} + {2'b00, n};
    return (s > 5'd15) ? 4'd15 : s[3:0];
  endfunction

endpackage

// File: rtl/dose_sequencer_if.sv
// Request, sensor and status bundle between the scheduler and the sequencer.
// master drives requests/sensor/ack, slave is the sequencer.
interface dose_sequencer_if;
  logic       morningReq;
  logic       afternoonReq;
  logic       eveningReq;
  logic       manualReq;
  logic       pillSensor;
  logic       ack;
  logic       stepPulse;
  logic       motorEnable;
  logic [4:0] slotIndex;
  logic [1:0] doseType;
  logic       busy;
  logic       doneP;
  logic       alarm;
  logic       empty;
  logic [3:0] missedCount;

  modport master (
    output morningReq, afternoonReq, eveningReq, manualReq,
    output pillSensor, ack,
    input  stepPulse, motorEnable, slotIndex, doseType,
    input  busy, doneP, alarm, empty, missedCount
  );

  modport slave (
    input  morningReq, afternoonReq, eveningReq, manualReq,
    input  pillSensor, ack,
    output stepPulse, motorEnable, slotIndex, doseType,
    output busy, doneP, alarm, empty, missedCount
  );
endinterface

// File: rtl/step_gen.sv
// Stepper strobe generator: clock divider plus step down-counter.
// Shared by full-slot advances and retry nudges.
module step_gen
  import dispenser_pkg::*;
#(
  parameter int STEP_DIV = STEP_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] count,
  input  logic             enable,
  output logic             stepPulse,
  output logic             finished
);
  localparam int DW = $clog2(STEP_DIV + 1);
  localparam logic [DW-1:0] DIV_TOP = DW'(STEP_DIV - 1);

  logic [DW-1:0]    div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  assign tick      = enable && (div_q == DIV_TOP) && (cnt_q != '0);
  assign stepPulse = tick;
  // a zero load finishes at once rather than spinning forever
  assign finished  = enable &&
                     ((cnt_q == '0) || (tick && cnt_q == CNT_W'(1)));

  always_comb begin
    div_d = '0;
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = count;
    end else if (enable) begin
      div_d = (div_q == DIV_TOP) ? '0 : div_q + DW'(1);
      if (tick) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/dose_sequencer.sv
// Carousel dose sequencer: queues dose requests, advances one slot per dose,
// confirms the drop, nudges on a miss and latches alarm/empty for a caregiver.
module dose_sequencer
  import dispenser_pkg::*;
#(
  parameter int STEP_DIV       = STEP_DIV_DEF,
  parameter int STEPS_PER_SLOT = STEPS_PER_SLOT_DEF,
  parameter int NUDGE_STEPS    = NUDGE_STEPS_DEF,
  parameter int DROP_TIMEOUT   = DROP_TIMEOUT_DEF,
  parameter int MAX_RETRY      = MAX_RETRY_DEF,
  parameter int NUM_SLOTS      = NUM_SLOTS_DEF
) (
  input logic             CLOCK_50,
  input logic             reset,
  dose_sequencer_if.slave io
);
  localparam int TW = $clog2(DROP_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e           state_q, state_d;
  logic [3:0]       pend_q, pend_d;
  dose_e            dose_q, dose_d;
  logic [4:0]       slot_q, slot_d;
  logic [3:0]       miss_q, miss_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             done_q, done_d;
  logic [2:0]       sync_q, sync_d;
  logic [3:0]       req, eff;
  logic             rise, adv;
  logic             sg_load, sg_en, sg_pulse, sg_fin;
  logic [CNT_W-1:0] sg_count;

  assign req  = {io.eveningReq, io.afternoonReq,
                 io.morningReq, io.manualReq};
  assign eff  = pend_q | req;
  assign rise = sync_q[1] & ~sync_q[2];

  step_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_step (
    .clk       (CLOCK_50),
    .rst_n     (reset),
    .load      (sg_load),
    .count     (sg_count),
    .enable    (sg_en),
    .stepPulse (sg_pulse),
    .finished  (sg_fin)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = eff;
    dose_d   = dose_q;
    slot_d   = slot_q;
    miss_d   = miss_q;
    retry_d  = retry_q;
    tmo_d    = '0;
    done_d   = 1'b0;
    sync_d   = {sync_q[1:0], io.pillSensor};
    sg_load  = 1'b0;
    sg_en    = 1'b0;
    sg_count = CNT_W'(STEPS_PER_SLOT);
    adv      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (eff != '0) begin
          state_d = S_ARM;
          if (eff[1])      dose_d = DOSE_MORNING;
          else if (eff[2]) dose_d = DOSE_AFTERNOON;
          else if (eff[3]) dose_d = DOSE_EVENING;
          else             dose_d = DOSE_MANUAL;
          pend_d[dose_d] = 1'b0;
        end
      end
      S_ARM: begin
        sg_load = 1'b1;
        state_d = S_STEP;
      end
      S_STEP, S_NUDGE: begin
        sg_en = 1'b1;
        if (sg_fin) state_d = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        tmo_d = tmo_q + TW'(1);
        // a detected drop wins over a timeout landing on the same cycle
        if (done_q) begin
          adv = 1'b1;
        end else if (rise) begin
          done_d = 1'b1;
        end else if (tmo_q == TW'(DROP_TIMEOUT - 1)) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d  = retry_q + RW'(1);
            sg_load  = 1'b1;
            sg_count = CNT_W'(NUDGE_STEPS);
            state_d  = S_NUDGE;
          end else begin
            miss_d  = sat_add(miss_q, 3'd1);
            state_d = S_ALARM;
          end
        end
      end
      S_ALARM: begin
        if (io.ack) adv = 1'b1;
      end
      S_EMPTY: begin
        miss_d = sat_add(miss_q, 3'($countones(eff)));
        pend_d = '0;
        if (io.ack) begin
          slot_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      retry_d = '0;
      if (slot_q == 5'(NUM_SLOTS - 1)) begin
        state_d = S_EMPTY;
      end else begin
        slot_d  = slot_q + 5'd1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      dose_q  <= DOSE_MANUAL;
      slot_q  <= '0;
      miss_q  <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      dose_q  <= dose_d;
      slot_q  <= slot_d;
      miss_q  <= miss_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      sync_q  <= sync_d;
    end
  end

  assign io.stepPulse   = sg_pulse;
  assign io.motorEnable = (state_q == S_ARM) || (state_q == S_STEP) ||
                          (state_q == S_NUDGE) ||
                          (state_q == S_WAIT_DROP);
  assign io.slotIndex   = slot_q;
  assign io.doseType    = dose_q;
  assign io.busy        = (state_q != S_IDLE);
  assign io.doneP       = done_q;
  assign io.alarm       = (state_q == S_ALARM) || (state_q == S_EMPTY);
  assign io.empty       = (state_q == S_EMPTY);
  assign io.missedCount = miss_q;
endmodule

// File: tb/tb_dose_sequencer.sv
// Directed bench for dose_sequencer with small timing parameters:
// a vector table for the dose/queue/empty flow plus retry, reset and glitch cases.
module tb_dose_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   pulse_tot;
  int   done_tot;

  dose_sequencer_if io ();

  dose_sequencer #(
    .STEP_DIV       (4),
    .STEPS_PER_SLOT (5),
    .NUDGE_STEPS    (2),
    .DROP_TIMEOUT   (20),
    .MAX_RETRY      (2),
    .NUM_SLOTS      (3)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .io       (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (io.stepPulse) pulse_tot++;
    if (io.doneP) done_tot++;
  end

  typedef struct packed {
    logic       busy;
    logic       motor;
    logic       step;
    logic       done;
    logic       alarm;
    logic       empty;
    logic [1:0] dose;
    logic [4:0] slot;
    logic [3:0] missed;
  } obs_t;

  typedef struct {
    string      name;
    int         n;
    logic [3:0] req;
    logic       sens;
    logic       ack;
    obs_t       exp;
  } vec_t;

  vec_t tbl[$];

  function automatic obs_t o(
    input logic b, input logic m, input logic s,
    input logic d, input logic a, input logic e,
    input logic [1:0] dt, input logic [4:0] sl,
    input logic [3:0] mc
  );
    obs_t r;
    r.busy = b; r.motor = m; r.step = s;
    r.done = d; r.alarm = a; r.empty = e;
    r.dose = dt; r.slot = sl; r.missed = mc;
    return r;
  endfunction

  function automatic vec_t mkv(
    input string nm, input int n, input logic [3:0] rq,
    input logic sn, input logic ak, input obs_t ex
  );
    vec_t v;
    v.name = nm; v.n = n; v.req = rq;
    v.sens = sn; v.ack = ak; v.exp = ex;
    return v;
  endfunction

  function automatic obs_t sample();
    return o(io.busy, io.motorEnable, io.stepPulse, io.doneP,
             io.alarm, io.empty, io.doseType, io.slotIndex,
             io.missedCount);
  endfunction

  task automatic check_obs(input string nm, input obs_t ex);
    obs_t act;
    act = sample();
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s: got busy=%b motor=%b step=%b done=%b alarm=%b empty=%b dose=%b slot=%0d missed=%0d, expected busy=%b motor=%b step=%b done=%b alarm=%b empty=%b dose=%b slot=%0d missed=%0d",
               nm, act.busy, act.motor, act.step, act.done, act.alarm,
               act.empty, act.dose, act.slot, act.missed,
               ex.busy, ex.motor, ex.step, ex.done, ex.alarm,
               ex.empty, ex.dose, ex.slot, ex.missed);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int ex);
    checks++;
    if (act != ex) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, ex);
    end
  endtask

  task automatic set_req(input logic [3:0] r, input logic a);
    io.eveningReq   = r[3];
    io.afternoonReq = r[2];
    io.morningReq   = r[1];
    io.manualReq    = r[0];
    io.ack          = a;
  endtask

  task automatic drive_req(input logic [3:0] r, input logic a);
    set_req(r, a);
    @(negedge clk);
    set_req(4'b0000, 1'b0);
  endtask

  task automatic wait_pulses(input int n, input int lim, output int seen);
    seen = 0;
    for (int k = 0; k < lim && seen < n; k++) begin
      @(negedge clk);
      if (io.stepPulse) seen++;
    end
  endtask

  initial begin
    int   seen;
    int   cyc;
    int   p;
    int   d0;
    obs_t zero;
    checks    = 0;
    failures  = 0;
    pulse_tot = 0;
    done_tot  = 0;
    zero      = o(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 4'd0);
    rst_n     = 1'b0;
    io.pillSensor = 1'b0;
    set_req(4'b0000, 1'b0);
    repeat (3) @(negedge clk);
    check_obs("reset_state", zero);
    rst_n = 1'b1;
    @(negedge clk);

    // single morning dose, then afternoon+evening together, then empty
    tbl.push_back(mkv("arm", 1, 4'b0010, 0, 0,
                      o(1, 1, 0, 0, 0, 0, 2'b01, 5'd0, 4'd0)));
    tbl.push_back(mkv("first_step", 4, 4'b0000, 0, 0,
                      o(1, 1, 1, 0, 0, 0, 2'b01, 5'd0, 4'd0)));
    tbl.push_back(mkv("fifth_step", 16, 4'b0000, 0, 0,
                      o(1, 1, 1, 0, 0, 0, 2'b01, 5'd0, 4'd0)));
    tbl.push_back(mkv("wait_drop", 1, 4'b0000, 0, 0,
                      o(1, 1, 0, 0, 0, 0, 2'b01, 5'd0, 4'd0)));
    tbl.push_back(mkv("sens_sync", 2, 4'b0000, 1, 0,
                      o(1, 1, 0, 0, 0, 0, 2'b01, 5'd0, 4'd0)));
    tbl.push_back(mkv("done_morn", 1, 4'b0000, 1, 0,
                      o(1, 1, 0, 1, 0, 0, 2'b01, 5'd0, 4'd0)));
    tbl.push_back(mkv("idle_slot1", 1, 4'b0000, 1, 0,
                      o(0, 0, 0, 0, 0, 0, 2'b01, 5'd1, 4'd0)));
    tbl.push_back(mkv("arm_aft", 1, 4'b1100, 0, 0,
                      o(1, 1, 0, 0, 0, 0, 2'b10, 5'd1, 4'd0)));
    tbl.push_back(mkv("wait_aft", 21, 4'b0000, 0, 0,
                      o(1, 1, 0, 0, 0, 0, 2'b10, 5'd1, 4'd0)));
    tbl.push_back(mkv("done_aft", 3, 4'b0000, 1, 0,
                      o(1, 1, 0, 1, 0, 0, 2'b10, 5'd1, 4'd0)));
    tbl.push_back(mkv("idle_slot2", 1, 4'b0000, 1, 0,
                      o(0, 0, 0, 0, 0, 0, 2'b10, 5'd2, 4'd0)));
    tbl.push_back(mkv("arm_eve", 1, 4'b0000, 0, 0,
                      o(1, 1, 0, 0, 0, 0, 2'b11, 5'd2, 4'd0)));
    tbl.push_back(mkv("wait_eve", 21, 4'b0000, 0, 0,
                      o(1, 1, 0, 0, 0, 0, 2'b11, 5'd2, 4'd0)));
    tbl.push_back(mkv("done_eve", 3, 4'b0000, 1, 0,
                      o(1, 1, 0, 1, 0, 0, 2'b11, 5'd2, 4'd0)));
    tbl.push_back(mkv("empty", 1, 4'b0000, 1, 0,
                      o(1, 0, 0, 0, 1, 1, 2'b11, 5'd2, 4'd0)));
    tbl.push_back(mkv("empty_miss", 1, 4'b0001, 0, 0,
                      o(1, 0, 0, 0, 1, 1, 2'b11, 5'd2, 4'd1)));
    tbl.push_back(mkv("refill", 1, 4'b0000, 0, 1,
                      o(0, 0, 0, 0, 0, 0, 2'b11, 5'd0, 4'd1)));
    tbl.push_back(mkv("idle_hold", 2, 4'b0000, 0, 0,
                      o(0, 0, 0, 0, 0, 0, 2'b11, 5'd0, 4'd1)));

    foreach (tbl[i]) begin
      io.pillSensor = tbl[i].sens;
      drive_req(tbl[i].req, tbl[i].ack);
      repeat (tbl[i].n - 1) @(negedge clk);
      check_obs(tbl[i].name, tbl[i].exp);
    end
    check_int("table_pulses", pulse_tot, 15);
    check_int("table_dones", done_tot, 3);

    // no sensor at all: two nudges then a latched alarm
    drive_req(4'b0010, 1'b0);
    cyc = 1;
    p = 0;
    while (!io.alarm && cyc < 200) begin
      if (io.stepPulse) p++;
      @(negedge clk);
      cyc++;
    end
    check_int("alarm_latency", cyc, 98);
    check_int("retry_pulses", p, 9);
    check_obs("alarm", o(1, 0, 0, 0, 1, 0, 2'b01, 5'd0, 4'd2));
    repeat (3) @(negedge clk);
    check_obs("alarm_held", o(1, 0, 0, 0, 1, 0, 2'b01, 5'd0, 4'd2));
    drive_req(4'b1000, 1'b1);
    check_obs("ack_req_idle", o(0, 0, 0, 0, 0, 0, 2'b01, 5'd1, 4'd2));
    @(negedge clk);
    check_obs("ack_req_arm", o(1, 1, 0, 0, 0, 0, 2'b11, 5'd1, 4'd2));

    // reset in the middle of a rotation with a request queued
    drive_req(4'b0001, 1'b0);
    wait_pulses(2, 40, seen);
    check_int("pre_reset_pulses", seen, 2);
    #1 rst_n = 1'b0;
    #1 check_obs("reset_async", zero);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_obs("reset_flags_clear", zero);

    // sensor glitch while stepping must not confirm a drop
    drive_req(4'b0010, 1'b0);
    d0 = done_tot;
    wait_pulses(1, 20, seen);
    check_int("glitch_first_pulse", seen, 1);
    io.pillSensor = 1'b1;
    repeat (2) @(negedge clk);
    io.pillSensor = 1'b0;
    wait_pulses(4, 40, seen);
    check_int("glitch_rest_pulses", seen, 4);
    repeat (2) @(negedge clk);
    check_int("glitch_no_donep", done_tot, d0);
    io.pillSensor = 1'b1;
    cyc = 0;
    while (!io.doneP && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check_int("donep_latency", cyc, 3);
    @(negedge clk);
    io.pillSensor = 1'b0;
    check_obs("glitch_dose_done", o(0, 0, 0, 0, 0, 0, 2'b01, 5'd1, 4'd0));
    check_int("single_donep", done_tot, d0 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
